// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier with a start/busy/done handshake.
// Latency: done is high in the cycle after edge E0+ITER (E0 = the edge that accepts start);
//   one op per ITER+2 cycles.
// Backpressure: none. start is sampled only in IDLE and ignored while busy; no queueing.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset; discards any in-flight op
//   start      request, sampled only in IDLE
//   is_signed  (only with MUL_UNSIGNED_EN) 1 = signed operands, 0 = unsigned; sampled with start
//   a          multiplicand
//   b          multiplier
//   busy       high in RUN and DONE
//   done       one-cycle pulse; result is valid from this cycle
//   result     2*WIDTH-bit product, registered, held until the next completion
//
// Optional feature: define MUL_UNSIGNED_EN to add the is_signed port. With it,
// operands are widened to WIDTH+1 bits and ITER = WIDTH+1 in both modes, so
// latency does not depend on signedness. Without it, operands are always
// signed and ITER = WIDTH.

module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef MUL_UNSIGNED_EN
  input  logic                 is_signed,
`endif
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

`ifdef MUL_UNSIGNED_EN
  localparam int ITER = WIDTH + 1;
`else
  localparam int ITER = WIDTH;
`endif
  // The multiplier register holds exactly one bit per Booth step.
  localparam int QW = ITER;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  // The accumulator is one bit wider than the operand, so -(-2^(W-1)) does not wrap.
  logic [WIDTH:0]      acc_q;
  logic [WIDTH:0]      m_q;
  logic [QW-1:0]       q_q;
  logic                q1_q;
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]  result_q;
  logic                busy_q;
  logic                done_q;

  // Operand extension applied at capture time.
  logic [WIDTH:0]      a_ext;
  logic [QW-1:0]       b_ext;

`ifdef MUL_UNSIGNED_EN
  always_comb begin
    a_ext = {is_signed & a[WIDTH-1], a};
    b_ext = {is_signed & b[WIDTH-1], b};
  end
`else
  always_comb begin
    a_ext = {a[WIDTH-1], a};
    b_ext = b;
  end
`endif

  // One Booth step: add or subtract m, then shift {acc,q,q_1} right arithmetically.
  logic [WIDTH:0]      sum_d;
  logic [WIDTH:0]      acc_d;
  logic [QW-1:0]       q_d;
  logic                q1_d;
  logic [2*WIDTH-1:0]  result_d;

  always_comb begin
    sum_d = acc_q;
    case ({q_q[0], q1_q})
      2'b10:   sum_d = acc_q - m_q;
      2'b01:   sum_d = acc_q + m_q;
      default: sum_d = acc_q;
    endcase
    acc_d    = {sum_d[WIDTH], sum_d[WIDTH:1]};
    q_d      = {sum_d[0], q_q[QW-1:1]};
    q1_d     = q_q[0];
    // The full product is exact in the low 2*WIDTH bits of the shifted {acc,q}.
    result_d = (2*WIDTH)'({acc_d, q_d});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q   <= '0;
            m_q     <= a_ext;
            q_q     <= b_ext;
            q1_q    <= 1'b0;
            cnt_q   <= CW'(ITER);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q - CW'(1);
          // Last step: capture the product now and pulse done next cycle.
          if (cnt_q == CW'(1)) begin
            result_q <= result_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: scoreboard bench for booth_mul_seq at WIDTH=8.
// Stimulus pushes expected products with their issue cycle; a monitor pops on done.
// The monitor also checks hold behaviour of result and that busy drops after done.

module tb_booth_mul_seq;

  localparam int W = 8;
`ifdef MUL_UNSIGNED_EN
  localparam int ITER = W + 1;
`else
  localparam int ITER = W;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [2*W-1:0] result;
`ifdef MUL_UNSIGNED_EN
  logic          is_signed;
`endif

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef MUL_UNSIGNED_EN
    .is_signed (is_signed),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*W-1:0] exp;
    int             iss;
  } exp_t;
  exp_t sb[$];

  bit          cur_sgn = 1'b1;
  logic [W-1:0] x, y;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer multiplication of the interpreted operands.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] xa, input logic [W-1:0] yb,
                                           input bit sg);
    longint px, py, p;
    px = sg ? longint'($signed(xa)) : longint'(xa);
    py = sg ? longint'($signed(yb)) : longint'(yb);
    p  = px * py;
    return p[2*W-1:0];
  endfunction

  // Issue one start pulse; the op is accepted at the next edge, then a/b are scrambled.
  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] yb, input logic [2*W-1:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    a     = xa;
    b     = yb;
    start = 1'b1;
`ifdef MUL_UNSIGNED_EN
    is_signed = cur_sgn;
`endif
    e.exp = exp;
    e.iss = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
`ifdef MUL_UNSIGNED_EN
    is_signed = 1'($urandom);
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compares every completion and the hold behaviour in between.
  logic [2*W-1:0] last_res = '0;
  bit             prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      last_res  = '0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got result %0h expected no completion", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.exp);
          chk("latency", cyc, e.iss + 1 + ITER);
          chk("busy_at_done", busy, 1);
        end
        last_res = result;
      end else begin
        chk("result_hold", result, last_res);
      end
      prev_done = done;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef MUL_UNSIGNED_EN
    is_signed = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_result", result, 0);
    rst_n = 1'b1;

    // Directed products, including the most-negative corner cases.
    op(8'd7,   8'd3,   16'h0015); wait_idle();
    op(8'hFB,  8'd6,   16'hFFE2); wait_idle();
    op(8'd6,   8'hFB,  16'hFFE2); wait_idle();
    op(8'h80,  8'h80,  16'h4000); wait_idle();
    op(8'h80,  8'h7F,  16'hC080); wait_idle();
    op(8'd5,   8'd0,   16'h0000); wait_idle();
    op(8'hFF,  8'hFF,  16'h0001); wait_idle();

    // start pulses during RUN and DONE must be ignored.
    op(8'd3, 8'd4, 16'h000C);
    repeat (2) @(posedge clk);
    #1; a = 8'd9; b = 8'd9; start = 1'b1;
    @(posedge clk);
    #1; start = 1'b0;
    repeat (ITER - 3) @(posedge clk);
    #1; a = 8'd9; b = 8'd9; start = 1'b1;
    @(posedge clk);
    #1; start = 1'b0;
    wait_idle();
    op(8'd9, 8'd9, 16'h0051); wait_idle();

    // Reset in the middle of an op discards it.
    op(8'd100, 8'd100, model(8'd100, 8'd100, 1'b1));
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    op(8'd2, 8'd2, 16'h0004); wait_idle();

    // start held high: back-to-back ops every ITER+2 cycles.
    begin
      exp_t e;
      int   base;
      @(posedge clk);
      #1;
      a = 8'd1; b = 8'hFF; start = 1'b1;
      base = cyc;
      for (int i = 0; i < 3; i++) begin
        e.exp = 16'hFFFF;
        e.iss = base + i * (ITER + 2);
        sb.push_back(e);
      end
      repeat (2 * (ITER + 2) + 1) @(posedge clk);
      #1; start = 1'b0;
      wait_idle();
    end

`ifdef MUL_UNSIGNED_EN
    cur_sgn = 1'b0;
    op(8'd255, 8'd255, 16'hFE01); wait_idle();
    cur_sgn = 1'b1;
    op(8'd255, 8'd255, 16'h0001); wait_idle();
`endif

    // Randomised ops, with spurious starts during RUN and random gaps.
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      if (i % 8 == 0) y = '0;
`ifdef MUL_UNSIGNED_EN
      cur_sgn = 1'($urandom_range(0, 1));
`endif
      op(x, y, model(x, y, cur_sgn));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, ITER - 2)) @(posedge clk);
        #1; a = W'($urandom); b = W'($urandom); start = 1'b1;
        @(posedge clk);
        #1; start = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
